// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared state encoding, default geometry and line record for the data caches.
package d_cache_pkg;
    typedef enum logic [1:0] {COMP, WB, ALLC} state_t;
    localparam int DEF_ADDR_W     = 30;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_SETS   = 8;
    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_CNT_W      = 32;
    localparam int OFF_W  = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W  = $clog2(DEF_NUM_SETS);
    localparam int TAG_W  = DEF_ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = DEF_LINE_WORDS * DEF_WORD_W;
    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;
endpackage

// File: rtl/d_cache_nway_lru.sv
// lru_nway: true-LRU age tracking per set; ages form a permutation with 0 as most recently used.
module lru_nway #(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 4,
    localparam int set_w = $clog2(NUM_SETS),
    localparam int way_w = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                access,
    input  logic [set_w-1:0]    access_set,
    input  logic [way_w-1:0]    access_way,
    input  logic [set_w-1:0]    victim_set,
    input  logic [NUM_WAYS-1:0] valid,
    output logic [way_w-1:0]    victim
);
    logic [way_w-1:0] age [NUM_SETS][NUM_WAYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age[s][w] <= way_w'(w);
        end else if (access) begin
            for (int w = 0; w < NUM_WAYS; w++)
                if (way_w'(w) == access_way)
                    age[access_set][w] <= '0;
                else if (age[access_set][w] < age[access_set][access_way])
                    age[access_set][w] <= age[access_set][w] + 1'b1;
        end
    end

    // Invalid ways take priority over the oldest one; the later loop wins.
    always_comb begin
        victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (age[victim_set][w] == way_w'(NUM_WAYS - 1))
                victim = way_w'(w);
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid[w])
                victim = way_w'(w);
    end
endmodule

// File: rtl/d_cache_nway.sv
// d_cache_nway: set-associative write-back, write-allocate data cache with true-LRU,
// byte strobes and saturating hit/miss counters.
module d_cache_nway import d_cache_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                                  clk,
    input  logic                                  proc_reset_n,
    input  logic                                  proc_read,
    input  logic                                  proc_write,
    input  logic [ADDR_W-1:0]                     proc_addr,
    input  logic [WORD_W-1:0]                     proc_wdata,
    input  logic [WORD_W/8-1:0]                   proc_wstrb,
    output logic [WORD_W-1:0]                     proc_rdata,
    output logic                                  proc_stall,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  mem_addr,
    output logic [LINE_WORDS*WORD_W-1:0]          mem_wdata,
    input  logic [LINE_WORDS*WORD_W-1:0]          mem_rdata,
    input  logic                                  mem_ready,
    output logic [CNT_W-1:0]                      hit_cnt,
    output logic [CNT_W-1:0]                      miss_cnt
);
    localparam int off_w  = $clog2(LINE_WORDS);
    localparam int idx_w  = $clog2(NUM_SETS);
    localparam int tag_w  = ADDR_W - off_w - idx_w;
    localparam int line_w = LINE_WORDS * WORD_W;
    localparam int way_w  = $clog2(NUM_WAYS);

    state_t state, state_nx;
    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty [NUM_SETS];
    logic [tag_w-1:0]    tags  [NUM_SETS][NUM_WAYS];
    logic [line_w-1:0]   data  [NUM_SETS][NUM_WAYS];
    logic [way_w-1:0]    victim, vic_q, hit_way;
    logic [ADDR_W-off_w-1:0] line_q;
    logic [off_w-1:0]    off;
    logic [idx_w-1:0]    idx, idx_q;
    logic [tag_w-1:0]    tag;
    logic [WORD_W-1:0]   wmask;
    logic [line_w-1:0]   lmask, ldata, hit_line, fill_line;
    logic                req, hit, serve, miss, fill, fill_wr;
    int                  base;

    assign off     = proc_addr[off_w-1:0];
    assign idx     = proc_addr[off_w+idx_w-1:off_w];
    assign tag     = proc_addr[ADDR_W-1:off_w+idx_w];
    assign idx_q   = line_q[idx_w-1:0];
    assign req     = proc_read | proc_write;
    assign serve   = req & hit;
    assign miss    = req & ~hit & (state == COMP);
    assign fill    = (state == ALLC) & mem_ready;
    assign fill_wr = proc_write & (proc_addr[ADDR_W-1:off_w] == line_q);
    assign proc_stall = req & ~hit;

    // Lookup only in COMP so a line being evicted or refilled never serves a request.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (state == COMP && valid[idx][w] && tags[idx][w] == tag) begin
                hit = 1'b1;
                hit_way = way_w'(w);
            end
    end

    always_comb begin
        base = int'(off) * WORD_W;
        wmask = '0;
        for (int b = 0; b < WORD_W/8; b++)
            wmask[8*b +: 8] = {8{proc_wstrb[b]}};
        lmask = line_w'(wmask) << base;
        ldata = line_w'(proc_wdata) << base;
        hit_line = (data[idx][hit_way] & ~lmask) | (ldata & lmask);
        fill_line = (mem_rdata & ~lmask) | (ldata & lmask);
        proc_rdata = WORD_W'(data[idx][hit_way] >> base);
    end

    always_comb begin
        state_nx = state;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_addr = proc_addr[ADDR_W-1:off_w];
        mem_wdata = data[idx_q][vic_q];
        unique case (state)
            COMP: if (miss) state_nx = dirty[idx][victim] ? WB : ALLC;
            WB: begin
                mem_write = ~mem_ready;
                mem_addr = {tags[idx_q][vic_q], idx_q};
                if (mem_ready) state_nx = ALLC;
            end
            ALLC: begin
                mem_read = ~mem_ready;
                mem_addr = line_q;
                if (mem_ready) state_nx = COMP;
            end
            default: state_nx = COMP;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= COMP;
            vic_q <= '0;
            line_q <= '0;
            hit_cnt <= '0;
            miss_cnt <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            state <= state_nx;
            if (miss) begin
                vic_q <= victim;
                line_q <= proc_addr[ADDR_W-1:off_w];
                if (!(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
            end
            if (serve) begin
                if (!(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
                if (proc_write) dirty[idx][hit_way] <= 1'b1;
            end
            if (fill) begin
                valid[idx_q][vic_q] <= 1'b1;
                dirty[idx_q][vic_q] <= fill_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (serve && proc_write) data[idx][hit_way] <= hit_line;
        if (fill) begin
            data[idx_q][vic_q] <= fill_wr ? fill_line : mem_rdata;
            tags[idx_q][vic_q] <= line_q[ADDR_W-off_w-1:idx_w];
        end
    end

    lru_nway #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
        .clk        (clk),
        .rst_n      (proc_reset_n),
        .access     (serve),
        .access_set (idx),
        .access_way (hit_way),
        .victim_set (idx),
        .valid      (valid[idx]),
        .victim     (victim)
    );
endmodule

// File: tb/tb_d_cache_nway.sv
// tb_d_cache_nway: scoreboard bench for d_cache_nway against an MRU-ordered set model
// and a flat word-level memory image.
module tb_d_cache_nway;
    import d_cache_pkg::*;
    localparam int NS = DEF_NUM_SETS;
    localparam int NWAYS = DEF_NUM_WAYS;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [3:0]   proc_wstrb;
    logic [31:0]  proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [31:0]  hit_cnt, miss_cnt;

    d_cache_nway dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_wstrb(proc_wstrb),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int tag; bit dirty;} mrec_t;
    typedef struct {int line; logic [127:0] data;} wb_t;
    typedef struct {bit wr; logic [31:0] exp;} sb_t;

    mrec_t       sets_q [NS][$];
    logic [31:0] gold [int];
    logic [31:0] mem_img [int];
    wb_t         wb_q [$];
    int          rf_q [$];
    sb_t         sb_q [$];
    int          m_hits, m_miss;
    int          checks = 0, passes = 0;
    bit          hold20 = 0, ready_off = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    function automatic logic [31:0] init_word(int a);
        return 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] mem_word(int a);
        return mem_img.exists(a) ? mem_img[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_word(int a);
        return gold.exists(a) ? gold[a] : mem_word(a);
    endfunction

    function automatic logic [127:0] gold_line(int line);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = gold_word(line*4 + i);
        return l;
    endfunction

    // Reference: each set is a recency list (front = most recent), at most NWAYS entries.
    task automatic model_access(input bit wr, input int addr, input logic [31:0] wd,
                                input logic [3:0] ws, output bit miss);
        int line = addr >> OFF_W;
        int s = line % NS;
        int t = line / NS;
        int pos = -1;
        mrec_t r;
        logic [31:0] w;
        for (int i = 0; i < sets_q[s].size(); i++) if (sets_q[s][i].tag == t) pos = i;
        if (pos < 0) begin
            miss = 1;
            m_miss++;
            if (sets_q[s].size() == NWAYS) begin
                r = sets_q[s].pop_back();
                if (r.dirty) wb_q.push_back('{r.tag*NS + s, gold_line(r.tag*NS + s)});
            end
            r = '{t, 1'b0};
            rf_q.push_back(line);
        end else begin
            miss = 0;
            r = sets_q[s][pos];
            sets_q[s].delete(pos);
        end
        if (wr) begin
            r.dirty = 1;
            w = gold_word(addr);
            for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            gold[addr] = w;
        end
        sets_q[s].push_front(r);
        m_hits++;
        sb_q.push_back('{wr, gold_word(addr)});
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) sets_q[s].delete();
        gold.delete();
        wb_q.delete();
        rf_q.delete();
        sb_q.delete();
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        proc_reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 proc_reset_n = 1;
    endtask

    task automatic do_req(input bit wr, input int addr, input logic [31:0] wd, input logic [3:0] ws);
        bit miss;
        int n = 0;
        model_access(wr, addr, wd, ws, miss);
        @(posedge clk); #1;
        proc_read = !wr;
        proc_write = wr;
        proc_addr = 30'(addr);
        proc_wdata = wd;
        proc_wstrb = ws;
        @(negedge clk);
        chk("first_stall", proc_stall, miss);
        while (proc_stall) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL req_timeout: addr %0h still stalled after %0d cycles, required served", addr, n);
                finish_run();
            end
        end
        @(posedge clk); #1;
        proc_read = 0;
        proc_write = 0;
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
    endtask

    // Monitor: every served processor cycle consumes one scoreboard entry.
    sb_t e;
    always @(negedge clk) begin
        if (proc_reset_n && (proc_read || proc_write) && !proc_stall) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_empty: served access at %0h, required no access", proc_addr);
            end else begin
                e = sb_q.pop_front();
                chk("served_kind", proc_write, e.wr);
                if (!e.wr) chk("rdata", proc_rdata, e.exp);
            end
        end
    end

    // Memory responder: random latency, checks each completed transfer against the model.
    int  d, k;
    bit  ab;
    wb_t wx;
    initial begin
        mem_ready = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (proc_reset_n && (mem_read || mem_write)) begin
                d = hold20 ? 20 : $urandom_range(0, 3);
                k = 0;
                ab = 0;
                while ((k < d || ready_off) && !ab) begin
                    if (hold20) chk("hold_read_stall", {mem_read, proc_stall}, 2'b11);
                    @(negedge clk);
                    k++;
                    if (!(mem_read || mem_write)) ab = 1;
                end
                if (!ab) begin
                    if (mem_write) begin
                        if (wb_q.size() == 0) begin
                            checks++;
                            $display("FAIL wb_unexpected: write-back of line %0h, required none", mem_addr);
                        end else begin
                            wx = wb_q.pop_front();
                            chk("wb_addr", mem_addr, wx.line);
                            chk("wb_data", mem_wdata, wx.data);
                        end
                        for (int i = 0; i < 4; i++) mem_img[int'(mem_addr)*4 + i] = mem_wdata[i*32 +: 32];
                    end else begin
                        if (rf_q.size() == 0) begin
                            checks++;
                            $display("FAIL rf_unexpected: refill of line %0h, required none", mem_addr);
                        end else chk("rf_addr", mem_addr, rf_q.pop_front());
                        for (int i = 0; i < 4; i++) mem_rdata[i*32 +: 32] = mem_word(int'(mem_addr)*4 + i);
                    end
                    mem_ready = 1;
                    @(negedge clk);
                    mem_ready = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        checks++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        finish_run();
    end

    initial begin
        int n;
        proc_reset_n = 0;
        proc_read = 0;
        proc_write = 0;
        proc_addr = '0;
        proc_wdata = '0;
        proc_wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", proc_stall, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        proc_reset_n = 1;

        // Cold read, then strobed write hit and read-back.
        do_req(0, 'h10, 0, 0);
        do_req(1, 'h11, 32'hAABBCCDD, 4'b0011);
        do_req(0, 'h11, 0, 0);

        // Five tags in set 0: the dirty first line is written back on the fifth miss.
        do_req(1, 'h00, $urandom, 4'hF);
        for (int i = 1; i < 5; i++) do_req(0, i*'h20, 0, 0);

        // Touching line 0 makes the clean line 0x8 the victim.
        do_reset();
        do_req(1, 'h00, $urandom, 4'hF);
        for (int i = 1; i < 4; i++) do_req(0, i*'h20, 0, 0);
        do_req(0, 'h01, 0, 0);
        do_req(0, 'h80, 0, 0);

        // Memory withholds ready for 20 cycles.
        do_reset();
        hold20 = 1;
        do_req(0, 'h100, 0, 0);
        hold20 = 0;

        // Reset while a write-back is outstanding.
        do_reset();
        do_req(1, 'h00, $urandom, 4'hF);
        for (int i = 1; i < 4; i++) do_req(0, i*'h20, 0, 0);
        ready_off = 1;
        @(posedge clk); #1;
        proc_read = 1;
        proc_addr = 30'h80;
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wb_seen", mem_write, 1);
        chk("wb_addr_rst", mem_addr, 0);
        @(posedge clk); #1;
        proc_reset_n = 0;
        #1;
        chk("rst_drop_write", mem_write, 0);
        chk("rst_drop_read", mem_read, 0);
        proc_read = 0;
        model_reset();
        ready_off = 0;
        repeat (2) @(posedge clk);
        #1 proc_reset_n = 1;
        do_req(0, 'h60, 0, 0);

        // Random traffic over 128 lines (16 tags per set).
        for (int i = 0; i < 400; i++)
            do_req(1'($urandom), int'($urandom_range(0, 511)), $urandom, 4'($urandom));

        chk("pending_wb", wb_q.size(), 0);
        chk("pending_rf", rf_q.size(), 0);
        chk("pending_sb", sb_q.size(), 0);
        finish_run();
    end
endmodule

// File: doc/d_cache_nway.md
Name: d_cache_nway

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the processor data port and the line-wide memory port.
- Next generation of the team's 2-way D-cache, adding:
  - configurable sets, ways and line length
  - true-LRU replacement
  - byte write strobes
  - hit/miss statistics counters
- Stalls the processor on a miss. Drives a held-until-ready memory handshake for write-back and refill.

Parameters:
- ADDR_W, 30, processor word-address width
- WORD_W, 32, processor word width (multiple of 8)
- LINE_WORDS, 4, words per line (power of 2, >=2)
- NUM_SETS, 8, number of sets (power of 2, >=2)
- NUM_WAYS, 4, ways per set (power of 2, 2..8)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock, all state on rising edge
- proc_reset_n  in  1  asynchronous active-low reset
- proc_read  in  1  read request, held until stall low
- proc_write  in  1  write request, held until stall low; never asserted together with proc_read
- proc_addr  in  ADDR_W  word address
- proc_wdata  in  WORD_W  write data
- proc_wstrb  in  WORD_W/8  byte enables for writes
- proc_rdata  out  WORD_W  read data, valid when proc_read & ~proc_stall
- proc_stall  out  1  request not yet served
- mem_read  out  1  line refill request
- mem_write  out  1  line write-back request
- mem_addr  out  ADDR_W-log2(LINE_WORDS)  line address
- mem_wdata  out  LINE_WORDS*WORD_W  write-back line
- mem_rdata  in  LINE_WORDS*WORD_W  refill line, valid while mem_ready
- mem_ready  in  1  memory completes current request
- hit_cnt  out  CNT_W  served hits, saturating
- miss_cnt  out  CNT_W  misses, saturating

Behaviour:
- Address split:
  - offset = low log2(LINE_WORDS) bits
  - index = next log2(NUM_SETS) bits
  - tag = remaining bits; TAG_W = ADDR_W-OFF_W-IDX_W (25 at defaults)
- Per line: valid, dirty, tag, data. Per set: LRU age per way, log2(NUM_WAYS) bits; ages in a set are always a permutation 0..NUM_WAYS-1, 0 = MRU.
- Reset (async, any state, mid-transaction included):
  - state=COMP; all valid/dirty=0; ages initialised to way index; counters=0
  - mem_read/mem_write fall in the same cycle (decoded from state)
- States:
  - COMP: no request -> stay. Hit -> stay. Miss: victim dirty -> WB, else -> ALLC; miss_cnt++ once on entry.
  - WB: mem_write=~mem_ready; mem_addr={victim tag, index}; mem_wdata=victim data. mem_ready -> ALLC.
  - ALLC: mem_read=~mem_ready; mem_addr=proc line address.
    - On mem_ready: victim line <= {valid=1, dirty=proc_write, tag, mem_rdata with strobed bytes merged if write}; -> COMP.
- Hit = any way in the set with valid & tag match (at most one).
- proc_stall = (proc_read|proc_write) & ~hit, combinational.
  - Read hit: zero-latency proc_rdata.
  - Miss: the request completes as a hit in the cycle after refill.
- Write hit: only bytes with proc_wstrb=1 are updated; dirty set. wstrb=0 leaves data unchanged but still marks dirty.
- LRU update on every served hit cycle (read or write):
  - accessed way -> 0
  - ways younger than its old age -> +1
  - others unchanged
- Victim selection:
  - lowest-numbered invalid way if any, else the way with age NUM_WAYS-1
  - latched on COMP->WB/ALLC, held until return to COMP
- hit_cnt++ on each cycle with a request & hit & state==COMP, so a refilled access counts as one miss plus one hit. Both counters saturate at all-ones.
- mem_addr in COMP = proc line address. mem_wdata don't-care outside WB.
- Request dropped during WB/ALLC: the transaction completes normally and the refilled line is installed clean.

Decomposition:
- Shared package d_cache_pkg holds:
  - state enum COMP/WB/ALLC
  - localparam derivations OFF_W, IDX_W, TAG_W, LINE_W
  - the line-record struct
- One natural sub-module, lru_nway: per-set age array with access-update and victim-select ports, reusable for the I-cache.

Test Plan:
All scenarios use defaults.
- Cold read 0x10 -> stall=1; mem_read=1 with mem_addr=0x4. After mem_ready with line {W3..W0} -> next cycle stall=0, proc_rdata=W0; miss_cnt=1, hit_cnt=1.
- Write 0x11 with wstrb=4'b0011, wdata=0xAABBCCDD on the resident line -> no stall. Read 0x11 returns W1[31:16]:0xCCDD.
- Five distinct tags mapping to set 0 (lines 0x0, 0x8, 0x10, 0x18, 0x20); write the first, then read the others in order:
  - 5th miss evicts line 0x0: mem_write with mem_addr=0x0 carrying the written data
  - then mem_read with mem_addr=0x20
- Touch line 0x0 between fills -> LRU keeps it; the victim becomes line 0x8, which is clean, so the next miss goes straight to mem_read.
- mem_ready held low 20 cycles -> mem_read stays 1 and stall stays 1 throughout, no state change.
- proc_reset_n pulsed low during WB -> mem_write drops immediately; after release the previous hit address misses.
